// File: rtl/jk_updn_counter_pkg.sv
// jk_updn_counter shared package:
// JK excitation codes and the default counter width.
package jk_updn_counter_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_updn_counter_if.sv
// jk_updn_counter bus: controls (en, up_dn, load, din, modulus) in,
// state (q, qb), per-bit excitation (jk_out) and terminal count (tc) out.
interface jk_updn_counter_if
  import jk_updn_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic               en;
  logic               up_dn;
  logic               load;
  logic [WIDTH-1:0]   din;
  logic [WIDTH-1:0]   modulus;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qb;
  logic [2*WIDTH-1:0] jk_out;
  logic               tc;

  modport master (
    output en, up_dn, load, din, modulus,
    input  q, qb, jk_out, tc
  );

  modport slave (
    input  en, up_dn, load, din, modulus,
    output q, qb, jk_out, tc
  );

endinterface

// File: rtl/jk_updn_counter_jk_cell.sv
// jk_cell: one JK flip-flop, async active-high reset to q = 0.
// Ports: clk, rst, jk[1:0] = {J,K}, q, qb = ~q.
module jk_cell
  import jk_updn_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] jk,
  output logic       q,
  output logic       qb
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      unique case (jk)
        JK_HOLD: r_q <= r_q;
        JK_CLR:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TGL:  r_q <= ~r_q;
      endcase
    end
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: rtl/jk_updn_counter.sv
// jk_updn_counter: modulo-N up/down counter built from JK cells.
// Ports: clk, rst (async, active high), bus (slave modport).
module jk_updn_counter
  import jk_updn_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
)(
  input  logic              clk,
  input  logic              rst,
  jk_updn_counter_if.slave  bus
);

  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_qb;
  logic [WIDTH-1:0]   w_next;
  logic [WIDTH-1:0]   w_nm1;
  logic [2*WIDTH-1:0] w_jk;
  logic               w_wrap;
  logic               w_up;
  logic               w_dn;
  logic               r_tc;

  assign w_up = !bus.load && bus.en && bus.up_dn;
  assign w_dn = !bus.load && bus.en && !bus.up_dn;

  // modulus 0 means 2^WIDTH, so N-1 falls out as all ones.
  assign w_nm1 = bus.modulus - WIDTH'(1);

  always_comb begin
    w_next = w_q;
    w_wrap = 1'b0;
    unique case (1'b1)
      bus.load: w_next = bus.din;
      w_up: begin
        if (w_q >= w_nm1) begin
          w_next = '0;
          w_wrap = 1'b1;
        end else begin
          w_next = w_q + WIDTH'(1);
        end
      end
      w_dn: begin
        if (w_q == '0) begin
          w_next = w_nm1;
          w_wrap = 1'b1;
        end else if (bus.modulus != '0 &&
                     w_q >= bus.modulus) begin
          // out-of-range after a load: clamp, not a wrap
          w_next = w_nm1;
        end else begin
          w_next = w_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_jk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_jk[2*i +: 2] = (w_next[i] ^ w_q[i]) ? JK_TGL : JK_HOLD;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .jk  (w_jk[2*g +: 2]),
      .q   (w_q[g]),
      .qb  (w_qb[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= w_wrap;
    end
  end

  assign bus.q      = w_q;
  assign bus.qb     = w_qb;
  assign bus.jk_out = w_jk;
  assign bus.tc     = r_tc;

endmodule
